// File: rtl/idma_pkg.sv
// Shared types and width helpers for the OBI read/write legalizer.
package idma_pkg;

    typedef enum logic {
        RW_COUPLED   = 1'b0,
        RW_DECOUPLED = 1'b1
    } rw_mode_e;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned offset_width(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/idma_legalizer_obi_chunker.sv
// Per-side chunk arithmetic: bytes left in the current bus word, the emitted
// chunk size after an optional cap from the opposite side, and the end lane.
module idma_legalizer_obi_chunker
    import idma_pkg::*;
#(
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned LenWidth  = 32,
    localparam int unsigned StrbWidth = strb_width(DataWidth),
    localparam int unsigned OW        = offset_width(DataWidth)
) (
    input  logic [OW-1:0]       lane,
    input  logic [LenWidth-1:0] len,
    input  logic [OW:0]         cap,
    output logic [OW:0]         avail,
    output logic [OW:0]         bytes,
    output logic [OW-1:0]       tailer
);

    localparam logic [OW:0] StrbBytes = (OW+1)'(StrbWidth);

    logic [OW:0] page_rem;

    assign page_rem = StrbBytes - {1'b0, lane};
    assign avail    = (len < LenWidth'(page_rem)) ? len[OW:0] : page_rem;
    assign bytes    = (cap < avail) ? cap : avail;
    // Wraps naturally to 0 when the chunk ends exactly on a word boundary.
    assign tailer   = lane + bytes[OW-1:0];

endmodule

// File: rtl/idma_legalizer_rw_obi.sv
// Splits 1D transfers into single-beat, word-bounded OBI read and write chunks.
// Optional chunk counters are enabled by defining IDMA_LEGALIZER_PERF_CNT_EN.
module idma_legalizer_rw_obi
    import idma_pkg::*;
#(
    parameter  int unsigned DataWidth    = 32,
    parameter  int unsigned AddrWidth    = 32,
    parameter  int unsigned LenWidth     = 32,
    parameter  bit          CombinedShft = 1'b0,
    localparam int unsigned StrbWidth    = strb_width(DataWidth),
    localparam int unsigned OW           = offset_width(DataWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [LenWidth-1:0]  req_len_i,
    input  logic [AddrWidth-1:0] req_src_i,
    input  logic [AddrWidth-1:0] req_dst_i,
    input  logic                 req_decouple_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [AddrWidth-1:0] r_addr_o,
    output logic [OW-1:0]        r_offset_o,
    output logic [OW-1:0]        r_tailer_o,
    output logic [OW-1:0]        r_shift_o,
    output logic                 r_last_o,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [AddrWidth-1:0] w_addr_o,
    output logic [OW-1:0]        w_offset_o,
    output logic [OW-1:0]        w_tailer_o,
    output logic [OW-1:0]        w_shift_o,
    output logic                 w_last_o,
    output logic [StrbWidth-1:0] w_be_o,
    output logic                 w_valid_o,
    input  logic                 w_ready_i,
    input  logic                 flush_i,
    input  logic                 kill_i,
    output logic                 done_o,
`ifdef IDMA_LEGALIZER_PERF_CNT_EN
    output logic [31:0]          r_chunks_o,
    output logic [31:0]          w_chunks_o,
`endif
    output logic                 r_busy_o,
    output logic                 w_busy_o
);

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [LenWidth-1:0]  len;
        logic                 valid;
    } mut_tf_t;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [OW-1:0]        offset;
        logic [OW-1:0]        tailer;
        logic [OW-1:0]        shift;
        logic                 last;
    } idma_obi_chunk_t;

    typedef struct packed {
        rw_mode_e      mode;
        logic [OW-1:0] r_shift;
        logic [OW-1:0] w_shift;
    } opt_t;

    localparam logic [OW:0] StrbBytes = (OW+1)'(StrbWidth);

    mut_tf_t         r_reg, r_next, w_reg, w_next;
    opt_t            opt_reg, opt_next;
    logic            done_reg, done_next;
    idma_obi_chunk_t r_chunk, w_chunk;

    logic            decoupled;
    logic [OW-1:0]   r_lane, w_lane, r_tail, w_tail;
    logic [OW:0]     r_avail, w_avail, r_cap, w_cap, r_bytes, w_bytes;
    logic            r_last, w_last, both_go, r_adv, w_adv, r_fin, w_fin, accept;
    logic [OW-1:0]   src_lane, dst_lane;
    logic [OW+1:0]   w_lane_end;

    assign decoupled = (opt_reg.mode == RW_DECOUPLED);
    assign r_lane    = r_reg.addr[OW-1:0];
    assign w_lane    = w_reg.addr[OW-1:0];
    // In coupled mode each side is capped by the other so both emit equal chunks.
    assign r_cap     = decoupled ? StrbBytes : w_avail;
    assign w_cap     = decoupled ? StrbBytes : r_avail;

    idma_legalizer_obi_chunker #(
        .DataWidth (DataWidth),
        .LenWidth  (LenWidth)
    ) u_r_chunker (
        .lane   (r_lane),
        .len    (r_reg.len),
        .cap    (r_cap),
        .avail  (r_avail),
        .bytes  (r_bytes),
        .tailer (r_tail)
    );

    idma_legalizer_obi_chunker #(
        .DataWidth (DataWidth),
        .LenWidth  (LenWidth)
    ) u_w_chunker (
        .lane   (w_lane),
        .len    (w_reg.len),
        .cap    (w_cap),
        .avail  (w_avail),
        .bytes  (w_bytes),
        .tailer (w_tail)
    );

    assign r_last  = (r_reg.len == LenWidth'(r_bytes));
    assign w_last  = (w_reg.len == LenWidth'(w_bytes));
    assign both_go = r_reg.valid & w_reg.valid & r_ready_i & w_ready_i & !flush_i;

    assign r_valid_o = decoupled ? (r_reg.valid & !flush_i) : both_go;
    assign w_valid_o = decoupled ? (w_reg.valid & !flush_i) : both_go;
    assign r_adv     = r_valid_o & r_ready_i;
    assign w_adv     = w_valid_o & w_ready_i;
    assign r_fin     = r_adv & r_last;
    assign w_fin     = w_adv & w_last;

    // Accepting while both sides retire their last chunk avoids an idle bubble.
    assign ready_o = (!r_reg.valid | r_fin) & (!w_reg.valid | w_fin) & !flush_i;
    assign accept  = valid_i & ready_o;

    assign src_lane = req_src_i[OW-1:0];
    assign dst_lane = req_dst_i[OW-1:0];

    always_comb begin
        r_next   = r_reg;
        w_next   = w_reg;
        opt_next = opt_reg;
        if (r_adv) begin
            r_next.addr  = r_reg.addr + AddrWidth'(r_bytes);
            r_next.len   = r_reg.len - LenWidth'(r_bytes);
            r_next.valid = !r_last;
        end
        if (w_adv) begin
            w_next.addr  = w_reg.addr + AddrWidth'(w_bytes);
            w_next.len   = w_reg.len - LenWidth'(w_bytes);
            w_next.valid = !w_last;
        end
        if (kill_i) begin
            r_next = '0;
            w_next = '0;
        end
        if (accept) begin
            r_next.addr      = req_src_i;
            r_next.len       = req_len_i;
            r_next.valid     = (req_len_i != '0);
            w_next.addr      = req_dst_i;
            w_next.len       = req_len_i;
            w_next.valid     = (req_len_i != '0);
            opt_next.mode    = req_decouple_i ? RW_DECOUPLED : RW_COUPLED;
            opt_next.r_shift = CombinedShft ? (src_lane - dst_lane) : src_lane;
            opt_next.w_shift = CombinedShft ? '0 : (OW'(0) - dst_lane);
        end
        done_next = (kill_i & (r_reg.valid | w_reg.valid))
                  | (accept & (req_len_i == '0))
                  | ((r_fin | w_fin) & (r_fin | !r_reg.valid) & (w_fin | !w_reg.valid));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_reg    <= '0;
            w_reg    <= '0;
            opt_reg  <= '0;
            done_reg <= 1'b0;
        end else begin
            r_reg    <= r_next;
            w_reg    <= w_next;
            opt_reg  <= opt_next;
            done_reg <= done_next;
        end
    end

`ifdef IDMA_LEGALIZER_PERF_CNT_EN
    logic [31:0] r_chunks_reg, w_chunks_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_chunks_reg <= '0;
            w_chunks_reg <= '0;
        end else begin
            if (r_adv) r_chunks_reg <= r_chunks_reg + 32'd1;
            if (w_adv) w_chunks_reg <= w_chunks_reg + 32'd1;
        end
    end

    assign r_chunks_o = r_chunks_reg;
    assign w_chunks_o = w_chunks_reg;
`endif

    assign r_chunk = '{addr:   {r_reg.addr[AddrWidth-1:OW], {OW{1'b0}}},
                       offset: r_lane,
                       tailer: r_tail,
                       shift:  opt_reg.r_shift,
                       last:   r_last};
    assign w_chunk = '{addr:   {w_reg.addr[AddrWidth-1:OW], {OW{1'b0}}},
                       offset: w_lane,
                       tailer: w_tail,
                       shift:  opt_reg.w_shift,
                       last:   w_last};

    assign r_addr_o   = r_chunk.addr;
    assign r_offset_o = r_chunk.offset;
    assign r_tailer_o = r_chunk.tailer;
    assign r_shift_o  = r_chunk.shift;
    assign r_last_o   = r_chunk.last;
    assign w_addr_o   = w_chunk.addr;
    assign w_offset_o = w_chunk.offset;
    assign w_tailer_o = w_chunk.tailer;
    assign w_shift_o  = w_chunk.shift;
    assign w_last_o   = w_chunk.last;

    assign w_lane_end = {2'b00, w_lane} + {1'b0, w_bytes};

    genvar gi;
    for (gi = 0; gi < StrbWidth; gi++) begin : gen_be
        assign w_be_o[gi] = ((OW+2)'(gi) >= {2'b00, w_lane}) && ((OW+2)'(gi) < w_lane_end);
    end

    assign done_o   = done_reg;
    assign r_busy_o = r_reg.valid;
    assign w_busy_o = w_reg.valid;

endmodule

// File: tb/tb_idma_legalizer_rw_obi.sv
// Directed bench for the OBI legalizer at DataWidth=32 (four byte lanes).
module tb_idma_legalizer_rw_obi;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] req_len_i = '0;
    logic [31:0] req_src_i = '0;
    logic [31:0] req_dst_i = '0;
    logic        req_decouple_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] r_addr_o, w_addr_o;
    logic [1:0]  r_offset_o, r_tailer_o, r_shift_o, w_offset_o, w_tailer_o, w_shift_o;
    logic        r_last_o, w_last_o, r_valid_o, w_valid_o;
    logic        r_ready_i = 1'b0;
    logic        w_ready_i = 1'b0;
    logic [3:0]  w_be_o;
    logic        flush_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        done_o, r_busy_o, w_busy_o;
`ifdef IDMA_LEGALIZER_PERF_CNT_EN
    logic [31:0] r_chunks_o, w_chunks_o;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    idma_legalizer_rw_obi #(
        .DataWidth    (32),
        .AddrWidth    (32),
        .LenWidth     (32),
        .CombinedShft (1'b0)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .req_len_i      (req_len_i),
        .req_src_i      (req_src_i),
        .req_dst_i      (req_dst_i),
        .req_decouple_i (req_decouple_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .r_addr_o       (r_addr_o),
        .r_offset_o     (r_offset_o),
        .r_tailer_o     (r_tailer_o),
        .r_shift_o      (r_shift_o),
        .r_last_o       (r_last_o),
        .r_valid_o      (r_valid_o),
        .r_ready_i      (r_ready_i),
        .w_addr_o       (w_addr_o),
        .w_offset_o     (w_offset_o),
        .w_tailer_o     (w_tailer_o),
        .w_shift_o      (w_shift_o),
        .w_last_o       (w_last_o),
        .w_be_o         (w_be_o),
        .w_valid_o      (w_valid_o),
        .w_ready_i      (w_ready_i),
        .flush_i        (flush_i),
        .kill_i         (kill_i),
        .done_o         (done_o),
`ifdef IDMA_LEGALIZER_PERF_CNT_EN
        .r_chunks_o     (r_chunks_o),
        .w_chunks_o     (w_chunks_o),
`endif
        .r_busy_o       (r_busy_o),
        .w_busy_o       (w_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_r(input string tag, input logic v, input logic [31:0] a,
                         input logic [1:0] off, input logic [1:0] tail, input logic last);
        chk({tag, ".r_valid"}, r_valid_o, v);
        chk({tag, ".r_addr"}, r_addr_o, a);
        chk({tag, ".r_offset"}, r_offset_o, off);
        chk({tag, ".r_tailer"}, r_tailer_o, tail);
        chk({tag, ".r_last"}, r_last_o, last);
    endtask

    task automatic chk_w(input string tag, input logic v, input logic [31:0] a,
                         input logic [1:0] off, input logic [1:0] tail,
                         input logic [3:0] be, input logic last);
        chk({tag, ".w_valid"}, w_valid_o, v);
        chk({tag, ".w_addr"}, w_addr_o, a);
        chk({tag, ".w_offset"}, w_offset_o, off);
        chk({tag, ".w_tailer"}, w_tailer_o, tail);
        chk({tag, ".w_be"}, w_be_o, be);
        chk({tag, ".w_last"}, w_last_o, last);
    endtask

    task automatic chk_idle(input string tag, input logic done);
        chk({tag, ".r_valid"}, r_valid_o, 1'b0);
        chk({tag, ".w_valid"}, w_valid_o, 1'b0);
        chk({tag, ".r_busy"}, r_busy_o, 1'b0);
        chk({tag, ".w_busy"}, w_busy_o, 1'b0);
        chk({tag, ".done"}, done_o, done);
    endtask

    // Presents a request for one cycle and expects it to be taken.
    task automatic req(input string tag, input logic [31:0] src, input logic [31:0] dst,
                       input logic [31:0] len, input logic dec);
        req_src_i      = src;
        req_dst_i      = dst;
        req_len_i      = len;
        req_decouple_i = dec;
        valid_i        = 1'b1;
        settle();
        chk({tag, ".accept_ready"}, ready_o, 1'b1);
        $display("req %s src=0x%08h dst=0x%08h len=%0d dec=%0b", tag, src, dst, len, dec);
        tick();
        valid_i = 1'b0;
    endtask

    initial begin
        // Reset values
        #1 rst_i = 1'b1;
        #2;
        chk_idle("rst", 1'b0);
        chk("rst.ready", ready_o, 1'b1);
        chk("rst.r_addr", r_addr_o, 32'h0);
        chk("rst.w_be", w_be_o, 4'b0000);
        chk("rst.r_tailer", r_tailer_o, 2'd0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        r_ready_i = 1'b1;
        w_ready_i = 1'b1;

        // Coupled unaligned: chunks of 2, 1, 3 bytes
        req("t1", 32'h1001, 32'h2002, 32'd6, 1'b0);
        settle();
        chk_r("t1c1", 1, 32'h1000, 2'd1, 2'd3, 0);
        chk_w("t1c1", 1, 32'h2000, 2'd2, 2'd0, 4'b1100, 0);
        chk("t1c1.r_shift", r_shift_o, 2'd1);
        chk("t1c1.w_shift", w_shift_o, 2'd2);
        chk("t1c1.ready", ready_o, 1'b0);
        tick();
        settle();
        chk_r("t1c2", 1, 32'h1000, 2'd3, 2'd0, 0);
        chk_w("t1c2", 1, 32'h2004, 2'd0, 2'd1, 4'b0001, 0);
        tick();
        settle();
        chk_r("t1c3", 1, 32'h1004, 2'd0, 2'd3, 1);
        chk_w("t1c3", 1, 32'h2004, 2'd1, 2'd0, 4'b1110, 1);
        chk("t1c3.ready", ready_o, 1'b1);
        chk("t1c3.done", done_o, 1'b0);
        tick();
        settle();
        chk_idle("t1end", 1'b1);
        tick();
        settle();
        chk("t1post.done", done_o, 1'b0);
        tick();

        // Decoupled with write side stalled
        w_ready_i = 1'b0;
        req("t2", 32'h1001, 32'h2002, 32'd6, 1'b1);
        settle();
        chk_r("t2r1", 1, 32'h1000, 2'd1, 2'd0, 0);
        chk_w("t2w0", 1, 32'h2000, 2'd2, 2'd0, 4'b1100, 0);
        tick();
        settle();
        chk_r("t2r2", 1, 32'h1004, 2'd0, 2'd3, 1);
        chk("t2r2.ready", ready_o, 1'b0);
        tick();
        settle();
        chk("t2stall.r_valid", r_valid_o, 1'b0);
        chk("t2stall.r_busy", r_busy_o, 1'b0);
        chk("t2stall.w_busy", w_busy_o, 1'b1);
        chk("t2stall.done", done_o, 1'b0);
        chk("t2stall.w_be", w_be_o, 4'b1100);
        tick();
        w_ready_i = 1'b1;
        settle();
        chk_w("t2w1", 1, 32'h2000, 2'd2, 2'd0, 4'b1100, 0);
        tick();
        settle();
        chk_w("t2w2", 1, 32'h2004, 2'd0, 2'd0, 4'b1111, 1);
        chk("t2w2.ready", ready_o, 1'b1);
        tick();
        settle();
        chk_idle("t2end", 1'b1);
        tick();

        // Back-to-back aligned requests
        req_src_i = 32'h100; req_dst_i = 32'h200; req_len_i = 32'd4; req_decouple_i = 1'b0;
        valid_i = 1'b1;
        settle();
        chk("t3a.ready", ready_o, 1'b1);
        tick();
        req_src_i = 32'h300; req_dst_i = 32'h400;
        settle();
        chk_r("t3a", 1, 32'h100, 2'd0, 2'd0, 1);
        chk("t3a.ready_on_last", ready_o, 1'b1);
        tick();
        valid_i = 1'b0;
        settle();
        chk_r("t3b", 1, 32'h300, 2'd0, 2'd0, 1);
        chk("t3b.w_addr", w_addr_o, 32'h400);
        chk("t3b.done_a", done_o, 1'b1);
        tick();
        settle();
        chk_idle("t3end", 1'b1);
        tick();
        settle();
        chk("t3post.done", done_o, 1'b0);
        tick();

        // Kill during the second of four chunks
        req("t4", 32'h10, 32'h20, 32'd16, 1'b0);
        settle();
        chk_r("t4c1", 1, 32'h10, 2'd0, 2'd0, 0);
        tick();
        kill_i = 1'b1;
        settle();
        chk_r("t4c2", 1, 32'h14, 2'd0, 2'd0, 0);
        tick();
        kill_i = 1'b0;
        settle();
        chk_idle("t4kill", 1'b1);
        chk("t4kill.r_addr", r_addr_o, 32'h0);
        tick();
        settle();
        chk("t4post.done", done_o, 1'b0);
        tick();

        // Flush for three cycles mid-transfer
        req("t5", 32'h40, 32'h80, 32'd12, 1'b0);
        settle();
        chk_r("t5c1", 1, 32'h40, 2'd0, 2'd0, 0);
        tick();
        flush_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("t5fl%0d.r_valid", i), r_valid_o, 1'b0);
            chk($sformatf("t5fl%0d.w_valid", i), w_valid_o, 1'b0);
            chk($sformatf("t5fl%0d.ready", i), ready_o, 1'b0);
            chk($sformatf("t5fl%0d.r_addr", i), r_addr_o, 32'h44);
            chk($sformatf("t5fl%0d.r_busy", i), r_busy_o, 1'b1);
            tick();
        end
        flush_i = 1'b0;
        settle();
        chk_r("t5c2", 1, 32'h44, 2'd0, 2'd0, 0);
        tick();
        settle();
        chk_r("t5c3", 1, 32'h48, 2'd0, 2'd0, 1);
        tick();
        settle();
        chk_idle("t5end", 1'b1);
        tick();

        // Zero-length request
        req("t6", 32'h1000, 32'h2000, 32'd0, 1'b0);
        settle();
        chk_idle("t6", 1'b1);
        chk("t6.ready", ready_o, 1'b1);
        tick();
        settle();
        chk("t6post.done", done_o, 1'b0);
        tick();

        // Address wrap at the top of the address space
        req("t7", 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd4, 1'b0);
        settle();
        chk_r("t7c1", 1, 32'hFFFF_FFFC, 2'd2, 2'd0, 0);
        chk_w("t7c1", 1, 32'hFFFF_FFFC, 2'd2, 2'd0, 4'b1100, 0);
        tick();
        settle();
        chk_r("t7c2", 1, 32'h0, 2'd0, 2'd2, 1);
        chk_w("t7c2", 1, 32'h0, 2'd0, 2'd2, 4'b0011, 1);
        tick();
        settle();
        chk_idle("t7end", 1'b1);
        tick();

        // Reset asserted mid-transfer
        req("t8", 32'h1003, 32'h2001, 32'd8, 1'b1);
        settle();
        chk("t8c1.r_valid", r_valid_o, 1'b1);
        chk("t8c1.r_shift", r_shift_o, 2'd3);
        chk("t8c1.w_shift", w_shift_o, 2'd3);
        rst_i = 1'b1;
        #1;
        chk_idle("t8rst", 1'b0);
        chk("t8rst.ready", ready_o, 1'b1);
        chk("t8rst.r_addr", r_addr_o, 32'h0);
        chk("t8rst.w_addr", w_addr_o, 32'h0);
        chk("t8rst.r_offset", r_offset_o, 2'd0);
        chk("t8rst.w_be", w_be_o, 4'b0000);
        chk("t8rst.r_shift", r_shift_o, 2'd0);
        chk("t8rst.w_shift", w_shift_o, 2'd0);
        tick();
        rst_i = 1'b0;
        tick();
        settle();
        chk_idle("t8after", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
